// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, instruction-memory request handshake, IF/ID register
// with a one-entry skid buffer, and redirect handling with in-flight response drop.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [6:0]  if_opcode
);

    typedef enum logic [1:0] {
        StBoot,
        StFetch,
        StHold,
        StDrop
    } state_e;

    localparam logic [31:0] PcMask      = 32'hFFFF_FFFC;
    localparam logic [31:0] ResetPcWord = RESET_PC & PcMask;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;

    logic [31:0] redirect_word;

    assign redirect_word = redirect_pc & PcMask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StBoot;
            pc_q         <= ResetPcWord;
            target_q     <= 32'h0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= 32'h0;
            if_instr_q   <= NOP_INSTR;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 32'h0;
            skid_instr_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            target_q     <= target_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        target_d     = target_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        imem_req     = 1'b0;

        unique case (state_q)
            StBoot: begin
                state_d = StFetch;
            end

            StFetch: begin
                imem_req = 1'b1;
                if (redirect) begin
                    if_valid_d   = 1'b0;
                    if_instr_d   = NOP_INSTR;
                    skid_valid_d = 1'b0;
                    if (imem_ready) begin
                        pc_d = redirect_word;
                    end else begin
                        // Response still owed for the old address; swallow it first.
                        target_d = redirect_word;
                        state_d  = StDrop;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_q + 32'd4;
                    if (!stall || !if_valid_q) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if_instr_d = imem_rdata;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_pc_d    = pc_q;
                        skid_instr_d = imem_rdata;
                        state_d      = StHold;
                    end
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                end
            end

            StHold: begin
                if (redirect) begin
                    if_valid_d   = 1'b0;
                    if_instr_d   = NOP_INSTR;
                    skid_valid_d = 1'b0;
                    pc_d         = redirect_word;
                    state_d      = StFetch;
                end else if (!stall) begin
                    if_valid_d   = skid_valid_q;
                    if_pc_d      = skid_pc_q;
                    if_instr_d   = skid_instr_q;
                    skid_valid_d = 1'b0;
                    state_d      = StFetch;
                end
            end

            StDrop: begin
                imem_req   = 1'b1;
                if_valid_d = 1'b0;
                if (redirect) begin
                    if_instr_d   = NOP_INSTR;
                    skid_valid_d = 1'b0;
                    if (imem_ready) begin
                        pc_d    = redirect_word;
                        state_d = StFetch;
                    end else begin
                        target_d = redirect_word;
                    end
                end else if (imem_ready) begin
                    pc_d    = target_q;
                    state_d = StFetch;
                end
            end

            default: begin
                state_d = StBoot;
            end
        endcase
    end

    // The address register only advances once the memory has answered.
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign if_opcode = if_instr_q[6:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized stall/redirect/latency,
// checked against an expected-PC stream model of the instruction flow into decode.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [6:0]  if_opcode;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .if_opcode  (if_opcode)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_pc = 32'h0;   // next PC decode must receive
    logic [31:0] key = 32'h0;      // memory content = address ^ key
    int          lat = 0;          // 0: zero-wait, >0: fixed wait, <0: random
    int          wait_cnt = 0;
    int          idle_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ key;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: pre-edge delivery check and drive, then post-edge checks at the negedge.
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
        logic        rdy;
        logic [31:0] w;
        logic        p_req, p_ready, p_valid;
        logic [31:0] p_addr, p_pc, p_instr;
        if (if_valid && !st && !rd) begin
            w = mem_word(exp_pc);
            chk("deliver_pc", if_pc, exp_pc);
            chk("deliver_instr", if_instr, w);
            chk("deliver_opcode", {25'd0, if_opcode}, {25'd0, w[6:0]});
            exp_pc   = exp_pc + 32'd4;
            idle_cnt = 0;
        end else if (!st && !rd) begin
            idle_cnt++;
        end
        if (rd) begin
            exp_pc   = rpc & 32'hFFFF_FFFC;
            idle_cnt = 0;
        end
        if (idle_cnt > 40) begin
            chk("progress_watchdog", idle_cnt, 0);
            idle_cnt = 0;
        end

        if (lat == 0) rdy = 1'b1;
        else if (lat > 0) rdy = (wait_cnt >= lat);
        else rdy = ($urandom_range(0, 1) == 1);
        rdy = rdy && imem_req;

        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ready  = rdy;
        imem_rdata  = rdy ? mem_word(imem_addr) : $urandom();

        p_req   = imem_req;
        p_ready = rdy;
        p_addr  = imem_addr;
        p_valid = if_valid;
        p_pc    = if_pc;
        p_instr = if_instr;

        @(negedge clk);
        wait_cnt = (p_req && !p_ready) ? wait_cnt + 1 : 0;

        if (rd) begin
            chk("flush_valid", {31'd0, if_valid}, 32'd0);
            chk("flush_instr", if_instr, NOP);
        end else if (p_valid && st) begin
            chk("hold_valid", {31'd0, if_valid}, 32'd1);
            chk("hold_pc", if_pc, p_pc);
            chk("hold_instr", if_instr, p_instr);
        end
        if (p_req && !p_ready) begin
            chk("req_held", {31'd0, imem_req}, 32'd1);
            chk("addr_held", imem_addr, p_addr);
        end
        if (imem_req) chk("addr_align", imem_addr & 32'd3, 32'd0);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, NOP);
        chk("rst_pc", if_pc, 32'd0);
        stall      = 1'b0;
        redirect   = 1'b0;
        imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        exp_pc   = 32'h0;
        wait_cnt = 0;
        idle_cnt = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        st, rd;
        logic [31:0] rpc;

        @(negedge clk);
        async_reset();

        // T1: boot latency and back-to-back fetch
        step(1'b0, 1'b0, 32'h0);
        chk("t1_boot_valid", {31'd0, if_valid}, 32'd0);
        chk("t1_boot_req", {31'd0, imem_req}, 32'd1);
        chk("t1_boot_addr", imem_addr, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("t1_first_valid", {31'd0, if_valid}, 32'd1);
        chk("t1_pc0", if_pc, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("t1_pc4", if_pc, 32'h4);
        step(1'b0, 1'b0, 32'h0);
        chk("t1_pc8", if_pc, 32'h8);
        chk("t1_instr_eq_pc", if_instr, 32'h8);

        // T2: stall with skid capture
        step(1'b1, 1'b0, 32'h0);
        chk("t2_stall_pc", if_pc, 32'h8);
        chk("t2_req_dropped", {31'd0, imem_req}, 32'd0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("t2_still_8", if_pc, 32'h8);
        step(1'b0, 1'b0, 32'h0);
        chk("t2_pc_c", if_pc, 32'hC);
        step(1'b0, 1'b0, 32'h0);
        chk("t2_pc_10", if_pc, 32'h10);

        // T3: redirect with zero-wait memory
        step(1'b0, 1'b1, 32'h100);
        chk("t3_addr", imem_addr, 32'h100);
        chk("t3_valid", {31'd0, if_valid}, 32'd0);
        step(1'b0, 1'b0, 32'h0);
        chk("t3_target_valid", {31'd0, if_valid}, 32'd1);
        chk("t3_target_pc", if_pc, 32'h100);

        // T4: redirect during a slow request
        lat = 3;
        step(1'b0, 1'b0, 32'h0);
        chk("t4_addr_old0", imem_addr, 32'h104);
        step(1'b0, 1'b1, 32'h200);
        chk("t4_addr_old1", imem_addr, 32'h104);
        chk("t4_drop_valid", {31'd0, if_valid}, 32'd0);
        step(1'b0, 1'b0, 32'h0);
        chk("t4_addr_old2", imem_addr, 32'h104);
        step(1'b0, 1'b0, 32'h0);
        chk("t4_addr_new", imem_addr, 32'h200);
        chk("t4_dropped_not_shown", {31'd0, if_valid}, 32'd0);
        repeat (4) step(1'b0, 1'b0, 32'h0);
        chk("t4_target_valid", {31'd0, if_valid}, 32'd1);
        chk("t4_target_pc", if_pc, 32'h200);

        // Randomized stall / redirect / latency against the stream model
        lat = -1;
        key = $urandom();
        step(1'b0, 1'b1, 32'h4000);
        for (int i = 0; i < 2000; i++) begin
            st = ($urandom_range(0, 99) < 30);
            rd = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            else rpc = $urandom();
            step(st, rd, rpc);
        end

        // T5: async reset while a dropped response is outstanding
        lat = 1000;
        repeat (3) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h300);
        chk("t5_drop_req", {31'd0, imem_req}, 32'd1);
        async_reset();
        lat = 0;
        step(1'b0, 1'b0, 32'h0);
        chk("t5_refetch_addr", imem_addr, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("t5_refetch_valid", {31'd0, if_valid}, 32'd1);
        chk("t5_refetch_pc", if_pc, 32'h0);

        // T6: unaligned target and PC wrap
        step(1'b0, 1'b1, 32'hFFFF_FFFE);
        chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        chk("t6_pc_top", if_pc, 32'hFFFF_FFFC);
        chk("t6_addr_wrap", imem_addr, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("t6_pc_wrap", if_pc, 32'h0);
        repeat (4) step(1'b0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
